// File: rtl/clk_freq_meter.sv
// Clock frequency meter: measures period and high time of SIG_in in CLK_in cycles,
// tracks period stability (LOCKED) and missing edges (STALL).
module clk_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT_CYC = 60000
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             EN,
  input  logic             SIG_in,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             LOCKED,
  output logic             STALL
);

  localparam int              RW     = $clog2(LOCK_COUNT + 1);
  localparam logic [RW-1:0]   LOCK_R = RW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, STALLED} state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] sync;
  logic                sig_s, sig_d, rise_q, hi_q;
  logic [CNT_W-1:0]    p, h;
  logic [RW-1:0]       r;

  assign sig_s = sync[SYNC_STAGES-1];

  // Edge and level are registered together so the FSM always sees the rising
  // edge and the high sample of the same cycle; this stage keeps running with EN low.
  always_ff @(posedge CLK_in) begin
    if (RST) begin
      sync   <= '0;
      sig_d  <= 1'b0;
      rise_q <= 1'b0;
      hi_q   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], SIG_in};
      sig_d  <= sig_s;
      rise_q <= sig_s & ~sig_d;
      hi_q   <= sig_s;
    end
  end

  always_ff @(posedge CLK_in) begin
    if (RST) begin
      state     <= IDLE;
      p         <= '0;
      h         <= '0;
      r         <= '0;
      PERIOD    <= '0;
      HIGH_TIME <= '0;
      VALID     <= 1'b0;
      LOCKED    <= 1'b0;
      STALL     <= 1'b0;
    end else begin
      VALID  <= 1'b0;
      LOCKED <= (r == LOCK_R);
      if (!EN) begin
        state  <= IDLE;
        LOCKED <= 1'b0;
        STALL  <= 1'b0;
        p      <= '0;
        h      <= '0;
        r      <= '0;
      end else begin
        case (state)
          IDLE: begin
            p <= '0;
            h <= '0;
            if (rise_q) begin
              p     <= ONE;
              h     <= ONE;
              r     <= '0;
              state <= RUN;
            end
          end
          RUN: begin
            if (rise_q) begin
              PERIOD    <= p;
              HIGH_TIME <= h;
              VALID     <= 1'b1;
              p         <= ONE;
              h         <= ONE;
              // First measurement after (re)start has no valid reference period.
              if (r == '0)             r <= RW'(1);
              else if (p == PERIOD)    r <= (r == LOCK_R) ? LOCK_R : r + RW'(1);
              else                     r <= RW'(1);
            end else if (p == TMO) begin
              STALL  <= 1'b1;
              LOCKED <= 1'b0;
              r      <= '0;
              state  <= STALLED;
            end else begin
              p <= p + ONE;
              h <= h + CNT_W'(hi_q);
            end
          end
          STALLED: begin
            if (rise_q) begin
              STALL <= 1'b0;
              p     <= ONE;
              h     <= ONE;
              r     <= '0;
              state <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: table of periodic patterns, hand sequences for
// switch/stall/reset/enable, and randomized segments against a queue-based model.
module tb_clk_freq_meter;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int LOCKN = 4;
  localparam int TMO   = 200;
  localparam int LAT   = SYNC + 1;

  logic             CLK_in, RST, EN, SIG_in;
  logic [CNT_W-1:0] PERIOD, HIGH_TIME;
  logic             VALID, LOCKED, STALL;

  clk_freq_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .LOCK_COUNT(LOCKN), .TIMEOUT_CYC(TMO)) dut (
    .CLK_in(CLK_in), .RST(RST), .EN(EN), .SIG_in(SIG_in),
    .PERIOD(PERIOD), .HIGH_TIME(HIGH_TIME), .VALID(VALID), .LOCKED(LOCKED), .STALL(STALL)
  );

  initial CLK_in = 1'b0;
  always #5 CLK_in = ~CLK_in;

  typedef struct { int hi; int lo; int n; int exp_p; int exp_h; int exp_lk; int exp_v; } vec_t;
  typedef struct { int p; int h; int lk; } exp_t;

  int   checks = 0, failures = 0;
  int   cyc = 0, vcount = 0, consec = 0;
  bit   prev_valid = 0, rand_mode = 0, lock_pending = 0;
  int   lock_exp = 0;
  int   rise_log[$];
  exp_t q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge numbers count posedges; a value driven at a negedge is sampled at edge cyc+1.
  task automatic seg(input int hi, input int lo);
    @(negedge CLK_in);
    SIG_in = 1'b1;
    rise_log.push_back(cyc + 1);
    repeat (hi - 1) @(negedge CLK_in);
    @(negedge CLK_in);
    SIG_in = 1'b0;
    repeat (lo - 1) @(negedge CLK_in);
  endtask

  task automatic low(input int n);
    repeat (n) begin
      @(negedge CLK_in);
      SIG_in = 1'b0;
    end
  endtask

  // what: 0 VALID, 1 STALL, 2 !STALL, 3 LOCKED, 4 VALID with PERIOD==10
  task automatic wait_for(input int what, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      bit hit;
      @(negedge CLK_in);
      case (what)
        0: hit = VALID;
        1: hit = STALL;
        2: hit = !STALL;
        3: hit = LOCKED;
        default: hit = VALID && (PERIOD == 16'd10);
      endcase
      if (hit) begin
        at = cyc;
        break;
      end
    end
  endtask

  always @(posedge CLK_in) begin
    #1;
    cyc++;
    if (lock_pending) begin
      chk("rand_locked", int'(LOCKED), lock_exp);
      lock_pending = 0;
    end
    if (VALID) begin
      vcount++;
      if (prev_valid) consec++;
      if (rand_mode) begin
        if (q.size() == 0) chk("rand_unexpected_valid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rand_period", int'(PERIOD), e.p);
          chk("rand_high", int'(HIGH_TIME), e.h);
          lock_exp     = e.lk;
          lock_pending = 1;
        end
      end
    end
    prev_valid = VALID;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   t, t2, x, j;
    tbl[0] = '{1, 1, 6, 2, 1, 1, 5};
    tbl[1] = '{5, 5, 6, 10, 5, 1, 6};
    tbl[2] = '{50, 50, 6, 100, 50, 1, 6};
    tbl[3] = '{3, 7, 3, 10, 3, 0, 3};
    tbl[4] = '{2, 1, 6, 3, 2, 1, 6};
    tbl[5] = '{4, 3, 4, 7, 4, 0, 4};
    tbl[6] = '{1, 9, 5, 10, 1, 1, 5};

    RST = 1'b1; EN = 1'b1; SIG_in = 1'b0;
    repeat (3) @(negedge CLK_in);
    chk("rst_period", int'(PERIOD), 0);
    chk("rst_high", int'(HIGH_TIME), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_locked", int'(LOCKED), 0);
    chk("rst_stall", int'(STALL), 0);
    RST = 1'b0;

    // Periodic patterns; each row ends with 5 low cycles so its last VALID lands in the row.
    for (int i = 0; i < 7; i++) begin
      int v0;
      v0 = vcount;
      for (int k = 0; k < tbl[i].n; k++) seg(tbl[i].hi, tbl[i].lo);
      low(5);
      chk($sformatf("row%0d_period", i), int'(PERIOD), tbl[i].exp_p);
      chk($sformatf("row%0d_high", i), int'(HIGH_TIME), tbl[i].exp_h);
      chk($sformatf("row%0d_locked", i), int'(LOCKED), tbl[i].exp_lk);
      chk($sformatf("row%0d_valids", i), vcount - v0, tbl[i].exp_v);
    end

    // /100 lock, then switch to /10: lock drops right after the first PERIOD=10 report.
    for (int k = 0; k < 6; k++) seg(50, 50);
    chk("div100_locked", int'(LOCKED), 1);
    fork
      for (int k = 0; k < 6; k++) seg(5, 5);
      begin
        wait_for(4, 400, t);
        chk("switch_found", int'(t >= 0), 1);
        chk("switch_locked_at_valid", int'(LOCKED), 1);
        @(negedge CLK_in);
        chk("switch_locked_after", int'(LOCKED), 0);
      end
    join
    low(5);
    chk("relock_div10", int'(LOCKED), 1);

    // Hold low: STALL after TMO cycles of counting, which starts LAT edges after the last rise.
    wait_for(1, 300, t);
    chk("stall_cycle", t, rise_log[$] + TMO + LAT);
    chk("stall_locked", int'(LOCKED), 0);
    chk("stall_period_hold", int'(PERIOD), 10);

    rise_log.delete();
    fork
      for (int k = 0; k < 6; k++) seg(5, 5);
      begin
        wait_for(2, 50, t);
        wait_for(0, 50, t2);
      end
    join
    chk("unstall_cycle", t, rise_log[0] + LAT);
    chk("restart_first_valid", t2, rise_log[1] + LAT);
    low(5);
    chk("restart_period", int'(PERIOD), 10);
    chk("restart_locked", int'(LOCKED), 1);

    // One-cycle reset mid-measurement while locked.
    low(3);
    RST = 1'b1;
    @(negedge CLK_in);
    RST = 1'b0;
    chk("midrst_period", int'(PERIOD), 0);
    chk("midrst_high", int'(HIGH_TIME), 0);
    chk("midrst_valid", int'(VALID), 0);
    chk("midrst_locked", int'(LOCKED), 0);
    chk("midrst_stall", int'(STALL), 0);
    @(negedge CLK_in);
    chk("midrst_no_valid", int'(VALID), 0);
    rise_log.delete();
    fork
      for (int k = 0; k < 3; k++) seg(5, 5);
      wait_for(0, 60, t);
    join
    chk("postrst_first_valid", t, rise_log[1] + LAT);
    chk("postrst_period", int'(PERIOD), 10);
    low(5);

    // EN low for 5 cycles while locked on /2.
    rise_log.delete();
    x = 0;
    fork
      for (int k = 0; k < 40; k++) seg(1, 1);
      begin
        repeat (30) @(negedge CLK_in);
        chk("en_pre_locked", int'(LOCKED), 1);
        EN = 1'b0;
        repeat (5) @(negedge CLK_in);
        chk("en_low_locked", int'(LOCKED), 0);
        chk("en_low_period", int'(PERIOD), 2);
        EN = 1'b1;
        x = cyc + 1;
        wait_for(0, 30, t);
        wait_for(3, 30, t2);
      end
    join
    j = 0;
    while (j < rise_log.size() && rise_log[j] + LAT < x) j++;
    chk("en_first_valid", t, rise_log[j + 1] + LAT);
    chk("en_relock", t2, rise_log[j + 4] + LAT + 1);
    low(5);

    // Randomized segments from idle; model reports each segment when the next one starts.
    EN = 1'b0;
    low(6);
    EN = 1'b1;
    rand_mode = 1;
    begin
      int lastp, lasth, prevrep, run, nrep;
      bit first;
      first = 1; nrep = 0; run = 0; prevrep = 0; lastp = 0; lasth = 0;
      for (int g = 0; g < 12; g++) begin
        int p, hi, reps;
        p    = $urandom_range(40, 2);
        hi   = $urandom_range(p - 1, 1);
        reps = $urandom_range(6, 1);
        for (int k = 0; k < reps; k++) begin
          if (!first) begin
            if (nrep == 0)             run = 1;
            else if (lastp == prevrep) run = (run < LOCKN) ? run + 1 : LOCKN;
            else                       run = 1;
            prevrep = lastp;
            nrep++;
            q.push_back('{lastp, lasth, int'(run == LOCKN)});
          end
          seg(hi, p - hi);
          lastp = p; lasth = hi; first = 0;
        end
      end
    end
    low(8);
    rand_mode = 0;
    chk("rand_queue_drained", q.size(), 0);
    chk("no_back_to_back_valid", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
